// File: rtl/frame_fetch_pkg.sv
// Shared pixel/frame constants and fetch FSM state encoding for the frame fetch path.
package frame_fetch_pkg;

    localparam int PIX_W        = 24;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/frame_fetch_skid_fifo.sv
// Small synchronous skid FIFO that catches ROM returns while the pixel FIFO is full.
module fetch_skid_fifo
    import frame_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PIX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Clear wins over a simultaneous push so a flush never keeps a stale pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/frame_fetch.sv
// Streams frame pixels from a synchronous ROM into the pixel FIFO, credit-limited so backpressure never loses data.
module frame_fetch
    import frame_fetch_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int PIXELS     = FRAME_PIXELS,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              restart,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [PIX_W-1:0]  fifo_wdata,
    output logic              frame_done,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(SKID_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    if (SKID_DEPTH < RD_LAT + 2) begin : g_depth_check
        $error("frame_fetch: SKID_DEPTH must be at least RD_LAT+2");
    end

    fetch_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  skid_count;
    logic [CNT_W:0]    credit_used;
    logic [RD_LAT-1:0] rd_valid;
    logic              tap;
    logic              flushing;
    logic              skid_clear;
    logic              skid_push;
    logic              skid_empty;
    logic [PIX_W-1:0]  skid_head;

    // Every outstanding read owns a skid slot, so a landing pixel always has room.
    assign credit_used = {1'b0, inflight} + {1'b0, skid_count};
    assign rom_en      = (state == ST_FETCH) && enable && (credit_used < (CNT_W+1)'(SKID_DEPTH));
    assign rom_addr    = addr;
    assign frame_done  = rom_en && (addr == LAST_ADDR);

    assign tap        = rd_valid[RD_LAT-1];
    assign flushing   = (state == ST_FLUSH);
    assign skid_clear = restart && !flushing;
    assign skid_push  = tap && !flushing;

    assign fifo_wr_en = !skid_empty && !fifo_full && !flushing;
    assign fifo_wdata = skid_empty ? '0 : skid_head;
    assign busy       = (state != ST_IDLE) || (inflight != '0) || !skid_empty;

    // Sequencer and address counter; FLUSH lingers until every abandoned read has returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else begin
            if (skid_clear) begin
                addr <= '0;
            end else if (rom_en) begin
                addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (restart)     state <= ST_FLUSH;
                    else if (enable) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (restart)      state <= ST_FLUSH;
                    else if (!enable) state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (inflight == '0) state <= enable ? ST_FETCH : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            inflight <= '0;
        end else begin
            rd_valid[0] <= rom_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_valid[i] <= rd_valid[i-1];
            end
            inflight <= inflight + CNT_W'(rom_en) - CNT_W'(tap);
        end
    end

    fetch_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .W     (PIX_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear),
        .push  (skid_push),
        .din   (rom_data),
        .pop   (fifo_wr_en),
        .dout  (skid_head),
        .count (skid_count),
        .empty (skid_empty)
    );

endmodule

// File: tb/tb_frame_fetch.sv
// Bench for frame_fetch: queue-based reference model checked every cycle, plus directed scenario checks.
module tb_frame_fetch;

    localparam int PIX    = 8;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        fifo_full = 1'b0;
    logic        rom_en;
    logic [23:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        fifo_wr_en;
    logic [23:0] fifo_wdata;
    logic        frame_done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int data;
        int cyc;
    } read_t;

    read_t pend[$];
    int    skid[$];
    read_t rd_tmp;
    int    m_state = M_IDLE;
    int    m_addr = 0;
    int    cyc = 0;
    int    ldata;
    int    old_pend;
    bit    e_en;
    bit    e_wr;
    bit    landed;
    bit    clr;

    frame_fetch #(
        .ADDR_W     (24),
        .PIXELS     (PIX),
        .RD_LAT     (RD_LAT),
        .SKID_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .restart    (restart),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ROM stand-in: data equals address, junk when not read so stray pushes show up.
    always @(posedge clk) begin
        rom_data <= rom_en ? rom_addr : 24'h5A5A5A;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic rs, input logic full);
        @(posedge clk);
        #1;
        enable    = en;
        restart   = rs;
        fifo_full = full;
        @(negedge clk);
        #1;
    endtask

    // Reference model: pending reads and skid contents as plain queues, advanced once per cycle.
    always @(negedge clk) begin
        if (rst) begin
            check_output("rst_rom_en", 32'(rom_en), 32'd0);
            check_output("rst_rom_addr", 32'(rom_addr), 32'd0);
            check_output("rst_wr_en", 32'(fifo_wr_en), 32'd0);
            check_output("rst_wdata", 32'(fifo_wdata), 32'd0);
            check_output("rst_busy", 32'(busy), 32'd0);
            pend.delete();
            skid.delete();
            m_state = M_IDLE;
            m_addr  = 0;
        end else begin
            e_en = (m_state == M_FETCH) && enable && ((pend.size() + skid.size()) < DEPTH);
            e_wr = (skid.size() != 0) && !fifo_full && (m_state != M_FLUSH);
            check_output("rom_en", 32'(rom_en), 32'(e_en));
            check_output("rom_addr", 32'(rom_addr), 32'(m_addr));
            check_output("frame_done", 32'(frame_done), 32'(e_en && (m_addr == PIX - 1)));
            check_output("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
            check_output("fifo_wdata", 32'(fifo_wdata), (skid.size() != 0) ? 32'(skid[0]) : 32'd0);
            check_output("busy", 32'(busy),
                         32'((m_state != M_IDLE) || (pend.size() != 0) || (skid.size() != 0)));
            check_output("credit", 32'((32'(dut.inflight) + 32'(dut.skid_count)) <= DEPTH), 32'd1);

            old_pend = pend.size();
            landed   = (pend.size() != 0) && (pend[0].cyc + RD_LAT == cyc);
            ldata    = landed ? pend[0].data : 0;
            if (landed) void'(pend.pop_front());
            clr = restart && (m_state != M_FLUSH);
            if (e_wr) void'(skid.pop_front());
            if (clr) skid.delete();
            else if (landed && m_state != M_FLUSH) skid.push_back(ldata);
            if (e_en) begin
                rd_tmp.data = m_addr;
                rd_tmp.cyc  = cyc;
                pend.push_back(rd_tmp);
                m_addr = (m_addr == PIX - 1) ? 0 : m_addr + 1;
            end
            if (clr) begin
                m_addr  = 0;
                m_state = M_FLUSH;
            end else if (m_state == M_IDLE && enable) begin
                m_state = M_FETCH;
            end else if (m_state == M_FETCH && !enable) begin
                m_state = M_IDLE;
            end else if (m_state == M_FLUSH && old_pend == 0) begin
                m_state = enable ? M_FETCH : M_IDLE;
            end
        end
        cyc++;
    end

    initial begin
        int  done_cnt;
        bit  found;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_rom_en", 32'(rom_en), 32'd0);
        rst = 1'b0;

        // Free flow and wrap at PIXELS=8: issue from cycle 1, writes trail by two cycles.
        done_cnt = 0;
        for (int n = 0; n < 13; n++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (n == 0) begin
                check_output("ff_first_rom_en", 32'(rom_en), 32'd0);
            end else begin
                check_output("ff_rom_en", 32'(rom_en), 32'd1);
                check_output("ff_rom_addr", 32'(rom_addr), 32'((n - 1) % 8));
                check_output("ff_frame_done", 32'(frame_done), 32'(((n - 1) % 8) == 7));
                if (n <= 10 && frame_done) done_cnt++;
            end
            if (n >= 3) begin
                check_output("ff_wr_en", 32'(fifo_wr_en), 32'd1);
                check_output("ff_wdata", 32'(fifo_wdata), 32'((n - 3) % 8));
            end else begin
                check_output("ff_wr_idle", 32'(fifo_wr_en), 32'd0);
            end
        end
        check_output("wrap_done_pulses", 32'(done_cnt), 32'd1);

        // Backpressure: credit runs out, issue stops, then the stream resumes.
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("bp_rom_en", 32'(rom_en), 32'd0);
        check_output("bp_wr_en", 32'(fifo_wr_en), 32'd0);
        check_output("bp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0);

        // Pause right after address 3 issues; resume must continue at 4.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (rom_en && rom_addr == 24'd3) found = 1'b1;
        end
        check_output("pause_reach_addr3", 32'(found), 32'd1);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("pause_drained", 32'(busy), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("resume_idle_cycle", 32'(rom_en), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("resume_rom_en", 32'(rom_en), 32'd1);
        check_output("resume_addr", 32'(rom_addr), 32'd4);

        // Restart while addr 5 issues, skid holds 3 and 4 is landing.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (rom_en && rom_addr == 24'd4 && fifo_wr_en) found = 1'b1;
        end
        check_output("restart_reach_addr4", 32'(found), 32'd1);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("restart_addr", 32'(rom_addr), 32'd5);
        check_output("restart_head", 32'(fifo_wdata), 32'd3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (fifo_wr_en) begin
                found = 1'b1;
                check_output("restart_first_data", 32'(fifo_wdata), 32'd0);
            end
        end
        check_output("restart_write_seen", 32'(found), 32'd1);

        // Asynchronous reset between edges, held across one falling edge.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check_output("arst_rom_en", 32'(rom_en), 32'd0);
        check_output("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_addr", 32'(rom_addr), 32'd0);
        check_output("arst_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("arst_idle_cycle", 32'(rom_en), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("arst_restart_en", 32'(rom_en), 32'd1);
        check_output("arst_restart_addr", 32'(rom_addr), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 9) != 0),
                           1'($urandom_range(0, 39) == 0),
                           1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("final_drain", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
